// File: rtl/instr_pkg.sv
// Shared encoding constants for the 5-bit-opcode, 32-bit instruction format.
// The control decoder imports the same package, so both sides agree on field layout.
package instr_pkg;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLL  = 4'd4,
    K_SRA  = 4'd5,
    K_ADDI = 4'd6,
    K_LW   = 4'd7,
    K_SW   = 4'd8
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2,
    ST_DONE = 2'd3
  } enc_state_e;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  localparam int OPC_LSB   = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;
  localparam int IMM_LSB   = 0;
  localparam int REG_W     = 5;
  localparam int IMM_W     = 17;

  function automatic logic [4:0] kind_to_aluop(input logic [3:0] kind);
    logic [4:0] op;
    op = ALU_ADD;
    case (kind)
      K_SUB:   op = ALU_SUB;
      K_AND:   op = ALU_AND;
      K_OR:    op = ALU_OR;
      K_SLL:   op = ALU_SLL;
      K_SRA:   op = ALU_SRA;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_word_enc.sv
// Combinational encoder: symbolic kind plus fields to a 32-bit machine word.
// Unused fields of each format are forced to zero; kinds 9-15 report illegal.
module instr_word_enc
  import instr_pkg::*;
(
  input  logic [3:0]       kind_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic [REG_W-1:0] shamt_i,
  input  logic [IMM_W-1:0] imm_i,
  output logic             legal_o,
  output logic [31:0]      word_o
);

  always_comb begin
    legal_o = 1'b1;
    word_o  = '0;
    case (kind_i)
      K_ADD, K_SUB, K_AND, K_OR: begin
        word_o[OPC_LSB   +: 5]     = OP_R;
        word_o[RD_LSB    +: REG_W] = rd_i;
        word_o[RS_LSB    +: REG_W] = rs_i;
        word_o[RT_LSB    +: REG_W] = rt_i;
        word_o[ALUOP_LSB +: 5]     = kind_to_aluop(kind_i);
      end
      // Shifts take their amount from shamt, so rt is meaningless and zeroed.
      K_SLL, K_SRA: begin
        word_o[OPC_LSB   +: 5]     = OP_R;
        word_o[RD_LSB    +: REG_W] = rd_i;
        word_o[RS_LSB    +: REG_W] = rs_i;
        word_o[SHAMT_LSB +: REG_W] = shamt_i;
        word_o[ALUOP_LSB +: 5]     = kind_to_aluop(kind_i);
      end
      K_ADDI, K_LW, K_SW: begin
        word_o[OPC_LSB +: 5]     = (kind_i == K_ADDI) ? OP_ADDI :
                                   (kind_i == K_LW)   ? OP_LW   : OP_SW;
        word_o[RD_LSB  +: REG_W] = rd_i;
        word_o[RS_LSB  +: REG_W] = rs_i;
        word_o[IMM_LSB +: IMM_W] = imm_i;
      end
      default: begin
        legal_o = 1'b0;
        word_o  = '0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction loader: encodes accepted operations and writes them
// sequentially into imem from a base address, one registered write per word.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [16:0]       in_imm,
  output logic              imem_wren,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              wren_q, wren_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic        enc_legal;
  logic [31:0] enc_word;
  logic        accept;

  instr_word_enc u_word_enc (
    .kind_i  (in_kind),
    .rd_i    (in_rd),
    .rs_i    (in_rs),
    .rt_i    (in_rt),
    .shamt_i (in_shamt),
    .imm_i   (in_imm),
    .legal_o (enc_legal),
    .word_o  (enc_word)
  );

  // start/stop are session commands and win over any operation offered alongside.
  assign in_ready = (state_q == ST_RUN) & ~start & ~stop;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    cnt_d   = cnt_q;
    full_d  = full_q;
    err_d   = err_q;
    if (start) begin
      state_d = ST_RUN;
      ptr_d   = base_addr;
      cnt_d   = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else if (stop && (state_q == ST_RUN || state_q == ST_FULL)) begin
      state_d = ST_DONE;
    end else if (accept) begin
      if (enc_legal) begin
        wren_d = 1'b1;
        addr_d = ptr_q;
        data_d = enc_word;
        ptr_d  = ptr_q + 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (ptr_q == PTR_LAST) begin
          state_d = ST_FULL;
          full_d  = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign imem_wren = wren_q;
  assign imem_addr = addr_q;
  assign imem_data = data_q;
  assign count     = cnt_q;
  assign full      = full_q;
  assign err       = err_q;
  assign busy      = (state_q == ST_RUN) | wren_q;

  // full is only set on entering FULL and cleared by start, so it excludes acceptance.
  a_full_blocks_accept: assert property (@(posedge clock) disable iff (!reset_n)
    full_q |-> !in_ready);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (12-bit and 2-bit address) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_instr_encoder;

  localparam int S_IDLE = 0, S_RUN = 1, S_FULL = 2, S_DONE = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [11:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_kind = '0;
  logic [4:0]  in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0;
  logic [16:0] in_imm = '0;

  logic        a_ready, a_wren, a_full, a_err, a_busy;
  logic [11:0] a_addr;
  logic [31:0] a_data;
  logic [12:0] a_count;
  logic        b_ready, b_wren, b_full, b_err, b_busy;
  logic [1:0]  b_addr;
  logic [31:0] b_data;
  logic [2:0]  b_count;

  instr_encoder #(.ADDR_W(12)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .base_addr(base_addr), .in_valid(in_valid), .in_ready(a_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_shamt(in_shamt), .in_imm(in_imm), .imem_wren(a_wren),
    .imem_addr(a_addr), .imem_data(a_data), .count(a_count),
    .full(a_full), .err(a_err), .busy(a_busy)
  );

  instr_encoder #(.ADDR_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .base_addr(base_addr[1:0]), .in_valid(in_valid), .in_ready(b_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_shamt(in_shamt), .in_imm(in_imm), .imem_wren(b_wren),
    .imem_addr(b_addr), .imem_data(b_data), .count(b_count),
    .full(b_full), .err(b_err), .busy(b_busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  int          aw     [2];
  int          m_state[2];
  int          m_ptr  [2];
  int          m_cnt  [2];
  int          m_addr [2];
  bit          m_err  [2];
  bit          m_full [2];
  bit          m_wren [2];
  logic [31:0] m_data [2];

  function automatic logic [31:0] model_word(input int kind, input int rd, input int rs,
                                             input int rt, input int sh, input int imm);
    logic [31:0] w;
    int opc;
    w = 32'(rd) * 32'h0040_0000 + 32'(rs) * 32'h0002_0000;
    if (kind <= 5) begin
      if (kind >= 4) w = w + 32'(sh) * 128;
      else           w = w + 32'(rt) * 4096;
      w = w + 32'(kind) * 4;
    end else begin
      opc = (kind == 6) ? 5 : (kind == 7) ? 8 : 7;
      w = w + 32'(opc) * 32'h0800_0000 + 32'(imm);
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = S_IDLE; m_ptr[i] = 0; m_cnt[i] = 0; m_addr[i] = 0;
      m_err[i] = 0; m_full[i] = 0; m_wren[i] = 0; m_data[i] = '0;
    end
  endtask

  task automatic model_step(input int i);
    int  last;
    bit  acc;
    last = (1 << aw[i]) - 1;
    m_wren[i] = 0;
    if (start) begin
      m_state[i] = S_RUN;
      m_ptr[i] = int'(base_addr) & last;
      m_cnt[i] = 0; m_err[i] = 0; m_full[i] = 0;
    end else begin
      acc = in_valid && (m_state[i] == S_RUN) && !stop;
      if (stop && (m_state[i] == S_RUN || m_state[i] == S_FULL)) m_state[i] = S_DONE;
      if (acc) begin
        if (in_kind <= 8) begin
          m_wren[i] = 1;
          m_addr[i] = m_ptr[i];
          m_data[i] = model_word(int'(in_kind), int'(in_rd), int'(in_rs), int'(in_rt),
                                 int'(in_shamt), int'(in_imm));
          if (m_cnt[i] < (1 << aw[i])) m_cnt[i]++;
          if (m_ptr[i] == last) begin
            m_state[i] = S_FULL; m_full[i] = 1;
          end
          m_ptr[i] = (m_ptr[i] + 1) & last;
        end else begin
          m_err[i] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_ready(input int i);
    return 32'((m_state[i] == S_RUN) && !start && !stop);
  endfunction

  function automatic logic [31:0] exp_busy(input int i);
    return 32'((m_state[i] == S_RUN) || m_wren[i]);
  endfunction

  task automatic compare_all();
    chk("a.ready", 32'(a_ready), exp_ready(0));
    chk("a.wren",  32'(a_wren),  32'(m_wren[0]));
    chk("a.addr",  32'(a_addr),  32'(m_addr[0]));
    chk("a.data",  a_data,       m_data[0]);
    chk("a.count", 32'(a_count), 32'(m_cnt[0]));
    chk("a.full",  32'(a_full),  32'(m_full[0]));
    chk("a.err",   32'(a_err),   32'(m_err[0]));
    chk("a.busy",  32'(a_busy),  exp_busy(0));
    chk("b.ready", 32'(b_ready), exp_ready(1));
    chk("b.wren",  32'(b_wren),  32'(m_wren[1]));
    chk("b.addr",  32'(b_addr),  32'(m_addr[1]));
    chk("b.data",  b_data,       m_data[1]);
    chk("b.count", 32'(b_count), 32'(m_cnt[1]));
    chk("b.full",  32'(b_full),  32'(m_full[1]));
    chk("b.err",   32'(b_err),   32'(m_err[1]));
    chk("b.busy",  32'(b_busy),  exp_busy(1));
  endtask

  // One clock: inputs already set; model follows the edge, outputs checked at negedge.
  task automatic step();
    @(posedge clock);
    if (reset_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clock);
    compare_all();
  endtask

  task automatic op(input bit v, input int k, input int rd, input int rs, input int rt,
                    input int sh, input int imm);
    in_valid = v; in_kind = 4'(k); in_rd = 5'(rd); in_rs = 5'(rs); in_rt = 5'(rt);
    in_shamt = 5'(sh); in_imm = 17'(imm);
  endtask

  task automatic session(input int base);
    op(0, 0, 0, 0, 0, 0, 0);
    start = 1; base_addr = 12'(base);
    step();
    start = 0;
  endtask

  initial begin
    aw[0] = 12; aw[1] = 2;
    model_reset();
    @(negedge clock);
    compare_all();
    chk("reset.ready", 32'(a_ready), 32'd0);
    chk("reset.count", 32'(a_count), 32'd0);
    reset_n = 1;
    step();

    // Single add at base 0.
    session(0);
    op(1, 0, 3, 1, 2, 0, 0); step();
    chk("add.wren", 32'(a_wren), 32'd1);
    chk("add.addr", 32'(a_addr), 32'd0);
    chk("add.data", a_data, 32'h00C2_2000);
    chk("add.count", 32'(a_count), 32'd1);
    op(0, 0, 0, 0, 0, 0, 0); step();

    // Back-to-back addi then sw.
    session(0);
    op(1, 6, 1, 0, 0, 0, 5); step();
    chk("addi.data", a_data, 32'h2840_0005);
    chk("addi.addr", 32'(a_addr), 32'd0);
    op(1, 8, 2, 1, 0, 0, 4); step();
    chk("sw.data", a_data, 32'h3882_0004);
    chk("sw.addr", 32'(a_addr), 32'd1);
    chk("sw.wren", 32'(a_wren), 32'd1);
    op(1, 4, 4, 2, 7, 3, 0); step();
    chk("sll.data", a_data, 32'h0104_0190);
    op(0, 0, 0, 0, 0, 0, 0); step();

    // Capacity limit on the 2-bit instance.
    session(2);
    op(1, 0, 1, 1, 1, 0, 0); step();
    chk("full.addr2", 32'(b_addr), 32'd2);
    step();
    chk("full.addr3", 32'(b_addr), 32'd3);
    chk("full.flag", 32'(b_full), 32'd1);
    chk("full.count", 32'(b_count), 32'd2);
    chk("full.ready", 32'(b_ready), 32'd0);
    step();
    chk("full.nowr", 32'(b_wren), 32'd0);
    start = 1; base_addr = 12'd2; step();
    start = 0; step();
    chk("reopen.wren", 32'(b_wren), 32'd1);
    chk("reopen.addr", 32'(b_addr), 32'd2);
    chk("reopen.count", 32'(b_count), 32'd1);
    op(0, 0, 0, 0, 0, 0, 0); step();

    // Illegal kind then legal at the same address.
    session(5);
    op(1, 12, 1, 1, 1, 1, 1); step();
    chk("ill.wren", 32'(a_wren), 32'd0);
    chk("ill.err", 32'(a_err), 32'd1);
    op(1, 0, 1, 1, 1, 0, 0); step();
    chk("ill.next", 32'(a_addr), 32'd5);
    session(5);
    chk("ill.clr", 32'(a_err), 32'd0);

    // start while a write is pending.
    op(1, 1, 7, 6, 5, 0, 0); step();
    start = 1; base_addr = 12'd20; step();
    chk("restart.count", 32'(a_count), 32'd0);
    start = 0; op(1, 2, 1, 2, 3, 0, 0); step();
    chk("restart.addr", 32'(a_addr), 32'd20);

    // Asynchronous reset with a write pending.
    session(0);
    op(1, 3, 9, 9, 9, 0, 0); step();
    reset_n = 0;
    #1;
    model_reset();
    chk("arst.wren", 32'(a_wren), 32'd0);
    chk("arst.data", a_data, 32'd0);
    chk("arst.busy", 32'(a_busy), 32'd0);
    compare_all();
    step();
    reset_n = 1;
    step();
    chk("arst.idle", 32'(a_ready), 32'd0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      base_addr = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(4088, 4095))
                                              : 12'($urandom);
      op($urandom_range(0, 9) < 7,
         ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 8)) : int'($urandom_range(9, 15)),
         int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
         int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
         int'($urandom_range(0, 131071)));
      if ($urandom_range(0, 149) == 0) begin
        reset_n = 0;
        #1;
        model_reset();
        compare_all();
        step();
        reset_n = 1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder and loader for the 5-bit-opcode, 32-bit processor: accepts symbolic operations (kind plus register/immediate fields) over a valid/ready handshake. Each one is encoded into the machine-word format that the control decoder consumes and written sequentially into instruction memory from a programmable base address. It sits between the test/boot loader and the imem write port, and is the encoding counterpart of the processor's control-signal decoder.

## Interface
- ADDR_W, 12, imem address width; session capacity up to 2^ADDR_W − base_addr words
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins session at base_addr
- stop  in  1  one-cycle pulse; ends session (→ DONE)
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  operation request valid
- in_ready  out  1  encoder can accept this cycle
- in_kind  in  4  0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra, 6 addi, 7 lw, 8 sw; 9–15 illegal
- in_rd, in_rs, in_rt, in_shamt  in  5 each  register/shift fields
- in_imm  in  17  immediate (addi/lw/sw)
- imem_wren  out  1  write strobe
- imem_addr  out  ADDR_W  write address
- imem_data  out  32  encoded word
- count  out  ADDR_W+1  words written this session
- full  out  1  last address consumed
- err  out  1  sticky: illegal kind accepted this session
- busy  out  1  state is RUN or a write is pending

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - FULL
  - DONE
- Transitions:
  - start from any state → RUN: ptr ← base_addr, count ← 0, err ← 0, full ← 0.
  - stop in RUN/FULL → DONE.
  - Accepting a legal kind with ptr = 2^ADDR_W−1 → FULL.
- in_ready = (state==RUN) & ~start & ~stop. start and stop dominate acceptance in the same cycle. start dominates stop.
- Accept = in_valid & in_ready.
  - Legal kind: the write register loads {ptr, encoded word} and ptr increments.
  - Illegal kind: handshake completes, nothing is written, ptr is unchanged, err ← 1.
- Encoding, R-type (kinds 0–5):
  - [31:27]=00000, [26:22]=rd, [21:17]=rs, [16:12]=rt, [11:7]=shamt, [6:2]=ALUop (kind 0–5 → 00000–00101), [1:0]=00.
  - sll/sra: rt field forced to 0.
  - add/sub/and/or: shamt field forced to 0.
- Encoding, I-type:
  - [31:27]=opcode (addi 00101, lw 01000, sw 00111), [26:22]=rd, [21:17]=rs, [16:0]=imm.
  - For sw, rd carries the data register.
- count increments on each imem_wren cycle and saturates at 2^ADDR_W.
- Reset values: in_ready 0, imem_wren 0, imem_addr 0, imem_data 0, count 0, full 0, err 0, busy 0, ptr 0.
- Reset mid-session: everything clears immediately and a pending write is dropped.
- start while a write is pending: the pending write still completes at its old address and is not counted in the new session's count.

## Timing
- Latency: accept at edge N → imem_wren=1 with addr/data valid during cycle N+1 (registered outputs). Strobe is one cycle per word.
- Throughput: one word per cycle; in_ready does not depend on imem_wren (no back-pressure from imem).
- FULL: in_ready falls the cycle after the accepting edge of the last address; full rises with that word's write cycle.
- stop/start take effect on the edge where they are sampled. A word accepted on an earlier edge is always written.

## Structure
- Shared package instr_pkg:
  - opcode constants OP_R, OP_ADDI, OP_LW, OP_SW.
  - ALUop constants.
  - kind enum.
  - Field bit positions.
  - These constants are shared with the control decoder.
- Sub-module instr_word_enc: purely combinational kind/fields → {legal, word[31:0]}. The top holds the FSM, ptr, write register and counters.

## Test plan
- add, rd=3, rs=1, rt=2, base_addr=0 → next cycle imem_wren=1, imem_addr=0, imem_data=0x00C22000, count=1.
- Back-to-back addi rd=1 rs=0 imm=5, then sw rd=2 rs=1 imm=4 → writes 0x28400005 @0, then 0x38820004 @1, on consecutive cycles.
- sll rd=4, rs=2, rt=7, shamt=3 → 0x01040190 (rt forced to 0).
- ADDR_W=2, base_addr=2, continuous valid → writes @2 and @3, then in_ready=0, full=1, count=2. A further start reopens the session at base.
- kind=12 accepted → no imem_wren, err=1, ptr unchanged. The following add is written at the same address. start clears err.
- reset_n low during a stream → all outputs 0 asynchronously, the pending write is dropped, and the state is IDLE with in_ready=0.
